// File: rtl/step_clock_gen.sv
// Push-button to single-step CPU clock: 2-flop synchronisers, debounce FSM,
// free-run divider and a fixed-width high/low pulse generator with a step counter.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PULSE_WIDTH     = 4,
  parameter int RUN_DIV         = 50_000_000,
  parameter int COUNT_W         = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               button,
  input  logic               run_mode,
  output logic               CLK_CPU,
  output logic               step_pulse,
  output logic               btn_level,
  output logic               busy,
  output logic [COUNT_W-1:0] step_count
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW  = $clog2(RUN_DIV + 1);
  localparam int PCW = $clog2(2 * PULSE_WIDTH + 1);

  localparam logic [DW-1:0]      D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]      D_ONE     = DW'(1);
  localparam logic [RW-1:0]      R_LAST    = RW'(RUN_DIV - 1);
  localparam logic [RW-1:0]      R_ONE     = RW'(1);
  localparam logic [PCW-1:0]     P_LAST    = PCW'(2 * PULSE_WIDTH - 1);
  localparam logic [PCW-1:0]     P_HI_LAST = PCW'(PULSE_WIDTH - 1);
  localparam logic [PCW-1:0]     P_ONE     = PCW'(1);
  localparam logic [COUNT_W-1:0] C_ONE     = COUNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_t;

  logic [1:0] raw_in;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       btn_s;
  logic       run_s;

  deb_state_t state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic          btn_req;

  logic [RW-1:0] rcnt_reg;
  logic          run_req;
  logic          step_req;

  logic               busy_reg;
  logic [PCW-1:0]     pcnt_reg;
  logic               clk_cpu_reg;
  logic               step_pulse_reg;
  logic [COUNT_W-1:0] step_count_reg;

  assign raw_in = {run_mode, button};
  assign btn_s  = sync_reg[0];
  assign run_s  = sync_reg[1];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= raw_in;
      sync_reg <= meta_reg;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  // A completed press only requests a step in single-step mode.
  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    btn_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          dcnt_next  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt_reg == D_LAST) begin
          state_next = PRESSED;
          dcnt_next  = '0;
          btn_req    = !run_s;
        end else begin
          dcnt_next = dcnt_reg + D_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          dcnt_next  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = PRESSED;
          dcnt_next  = '0;
        end else if (dcnt_reg == D_LAST) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + D_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        dcnt_next  = '0;
      end
    endcase
  end

  assign run_req  = run_s && (rcnt_reg == R_LAST);
  assign step_req = btn_req || run_req;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rcnt_reg <= '0;
    end else if (!run_s || run_req) begin
      rcnt_reg <= '0;
    end else begin
      rcnt_reg <= rcnt_reg + R_ONE;
    end
  end

  // Requests landing inside an active high+low window are dropped, not queued.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      busy_reg       <= 1'b0;
      pcnt_reg       <= '0;
      clk_cpu_reg    <= 1'b0;
      step_pulse_reg <= 1'b0;
      step_count_reg <= '0;
    end else if (step_req && !busy_reg) begin
      busy_reg       <= 1'b1;
      pcnt_reg       <= '0;
      clk_cpu_reg    <= 1'b1;
      step_pulse_reg <= 1'b1;
      step_count_reg <= step_count_reg + C_ONE;
    end else begin
      step_pulse_reg <= 1'b0;
      if (busy_reg) begin
        if (pcnt_reg == P_LAST) begin
          busy_reg    <= 1'b0;
          pcnt_reg    <= '0;
          clk_cpu_reg <= 1'b0;
        end else begin
          pcnt_reg    <= pcnt_reg + P_ONE;
          clk_cpu_reg <= (pcnt_reg < P_HI_LAST);
        end
      end
    end
  end

  assign CLK_CPU    = clk_cpu_reg;
  assign step_pulse = step_pulse_reg;
  assign btn_level  = (state_reg == PRESSED);
  assign busy       = busy_reg;
  assign step_count = step_count_reg;

endmodule
